nav_drive_ctrl: RTL
===================

// Module: nav_drive_ctrl
// PURPOSE
//  Consumer of the camera detector's per-frame steering code (operate_mode: LEFT=3'b100,
//  MIDDLE=3'b010, RIGHT=3'b001, NO_COLOR=3'b000). Filters the decisions across frames,
//  runs the drive state machine and generates PWM/direction for the two drive motors.
//  Sits between cam_detect and the motor driver pins.
// PARAMETERS
//  PWM_PERIOD     1000  PWM counter period in clk cycles (counter runs 0..PWM_PERIOD-1)
//  FWD_DUTY       700   high cycles per period in FORWARD
//  TURN_DUTY      500   high cycles per period in TURN_L / TURN_R
//  SCAN_DUTY      300   high cycles per period in SCAN
//  CONFIRM_FRAMES 2     consecutive equal LEFT/MIDDLE/RIGHT frames needed to steer
//  LOST_FRAMES    4     consecutive NO_COLOR frames needed to fall back to SCAN
//  TICK_TIMEOUT   2000000  clk cycles without frame_tick before entering STALL
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  enable        in   1   drive enable; low forces IDLE
//  frame_tick    in   1   1-cycle pulse at last pixel of frame; operate_mode sampled here
//  operate_mode  in   3   steering code from the camera detector
//  pwm_left      out  1   left motor PWM
//  pwm_right     out  1   right motor PWM
//  dir_left      out  1   left motor direction, 1 = forward
//  dir_right     out  1   right motor direction, 1 = forward
//  state         out  3   IDLE=0 SCAN=1 FORWARD=2 TURN_L=3 TURN_R=4 STALL=5
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, pwm counter 0, cand=NO_COLOR, cand_cnt=0, timeout cnt 0.
//  - Any code other than the four legal codes is treated as NO_COLOR.
//  - Filter, updated only on frame_tick: code==cand -> cand_cnt++ (saturates at
//    max(CONFIRM_FRAMES,LOST_FRAMES)); else cand<=code, cand_cnt<=1.
//    Accept = (cand steering code and new cnt>=CONFIRM_FRAMES) or (cand NO_COLOR and new
//    cnt>=LOST_FRAMES). Filter and accept are evaluated on the same tick; state changes
//    on the next clk edge (1-cycle latency from tick to state).
//  - FSM: enable=0 in any state -> IDLE next cycle; filter and timeout cleared.
//    IDLE & enable -> SCAN. SCAN/FORWARD/TURN_L/TURN_R on accept: MIDDLE->FORWARD,
//    LEFT->TURN_L, RIGHT->TURN_R, NO_COLOR->SCAN. No accept -> hold state.
//    Not IDLE/STALL and TICK_TIMEOUT cycles with no frame_tick -> STALL; filter cleared.
//    STALL -> SCAN on next frame_tick (that tick is fed to filter as first frame).
//  - Timeout counter clears on every frame_tick and in IDLE/STALL.
//  - Outputs (registered, 1 cycle after state): FORWARD dirs 1/1, duty FWD_DUTY;
//    TURN_L dirs 0/1, TURN_R dirs 1/0, duty TURN_DUTY; SCAN dirs 1/0, duty SCAN_DUTY;
//    IDLE/STALL dirs 0/0, pwm 0.
//  - PWM counter free-runs from reset, wraps PWM_PERIOD-1 -> 0; pwm = (cnt < duty).
//    duty>=PWM_PERIOD -> constant 1; duty 0 -> constant 0. Both motors share one counter.
//  - State change does not restart the PWM counter; new duty applies the next cycle.
//  - reset mid-operation overrides everything; frame_tick during reset is ignored.
// TESTING (PWM_PERIOD=10, FWD_DUTY=7, TURN_DUTY=5, SCAN_DUTY=3, CONFIRM=2, LOST=3, TIMEOUT=50)
//  1 reset, enable=1 -> state IDLE then SCAN 1 cycle later; pwm_left high 3 of 10 cycles,
//    dir_left=1, dir_right=0.
//  2 two ticks MIDDLE -> state=FORWARD 1 cycle after 2nd tick; one tick only -> stays SCAN;
//    pwm 7/10 both, dirs 1/1.
//  3 FORWARD, ticks LEFT,MIDDLE,LEFT,LEFT -> TURN_L only after 4th tick; dirs 0/1, duty 5/10.
//  4 FORWARD, ticks NO_COLOR x2 -> hold FORWARD; 3rd NO_COLOR -> SCAN; code 3'b111 counts
//    as NO_COLOR.
//  5 TURN_R, no tick for 50 cycles -> STALL, pwm 0, dirs 0; next tick MIDDLE -> SCAN; one
//    more MIDDLE tick -> FORWARD.
//  6 enable 0 while FORWARD -> IDLE next cycle, outputs 0; reset asserted mid-PWM-high ->
//    all outputs 0 on next edge, counter 0.

Source files
------------

// File: rtl/nav_drive_ctrl.sv
// Drive controller: debounces per-frame steering codes from the camera detector,
// runs the drive state machine and produces shared-counter PWM plus direction per motor.
module nav_drive_ctrl #(
  parameter int PWM_PERIOD     = 1000,
  parameter int FWD_DUTY       = 700,
  parameter int TURN_DUTY      = 500,
  parameter int SCAN_DUTY      = 300,
  parameter int CONFIRM_FRAMES = 2,
  parameter int LOST_FRAMES    = 4,
  parameter int TICK_TIMEOUT   = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [2:0] operate_mode,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic       dir_left,
  output logic       dir_right,
  output logic [2:0] state
);

  localparam int CNT_MAX  = (CONFIRM_FRAMES > LOST_FRAMES) ? CONFIRM_FRAMES : LOST_FRAMES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int TW       = $clog2(TICK_TIMEOUT + 1);
  localparam int MAX_A    = (PWM_PERIOD > FWD_DUTY) ? PWM_PERIOD : FWD_DUTY;
  localparam int MAX_B    = (TURN_DUTY > SCAN_DUTY) ? TURN_DUTY : SCAN_DUTY;
  localparam int DUTY_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // Counter and duty share one width so duties at or above the period compare correctly.
  localparam int PW       = $clog2(DUTY_MAX + 1);

  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
  localparam logic [CW-1:0] CONFIRM_C = CW'(CONFIRM_FRAMES);
  localparam logic [CW-1:0] LOST_C    = CW'(LOST_FRAMES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TICK_TIMEOUT - 1);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);

  localparam logic [2:0] CODE_LEFT   = 3'b100;
  localparam logic [2:0] CODE_MIDDLE = 3'b010;
  localparam logic [2:0] CODE_RIGHT  = 3'b001;
  localparam logic [2:0] CODE_NONE   = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    FORWARD = 3'd2,
    TURN_L  = 3'd3,
    TURN_R  = 3'd4,
    STALL   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cand_q, cand_d, code;
  logic [CW-1:0] cand_cnt_q, cand_cnt_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [PW-1:0] pwm_cnt_q, duty;
  logic          accept, dir_l_d, dir_r_d;

  function automatic state_t steer_target(input logic [2:0] c);
    case (c)
      CODE_MIDDLE: return FORWARD;
      CODE_LEFT:   return TURN_L;
      CODE_RIGHT:  return TURN_R;
      default:     return SCAN;
    endcase
  endfunction

  // NOTE: every signal driven here gets a default first, otherwise paths that skip
  // an assignment would infer a latch.
  always_comb begin
    code       = CODE_NONE;
    cand_d     = cand_q;
    cand_cnt_d = cand_cnt_q;
    timeout_d  = timeout_q;
    state_d    = state_q;

    case (operate_mode)
      CODE_LEFT, CODE_MIDDLE, CODE_RIGHT: code = operate_mode;
      default:                            code = CODE_NONE;
    endcase

    if (frame_tick) begin
      if (code == cand_q) begin
        cand_cnt_d = (cand_cnt_q == CNT_SAT) ? cand_cnt_q : cand_cnt_q + 1'b1;
      end else begin
        cand_d     = code;
        cand_cnt_d = CW'(1);
      end
    end
    accept = frame_tick && ((cand_d != CODE_NONE) ? (cand_cnt_d >= CONFIRM_C)
                                                  : (cand_cnt_d >= LOST_C));

    case (state_q)
      IDLE: begin
        state_d   = SCAN;
        timeout_d = '0;
      end
      STALL: begin
        timeout_d = '0;
        if (frame_tick) state_d = SCAN;
      end
      default: begin
        if (frame_tick) begin
          timeout_d = '0;
          if (accept) state_d = steer_target(cand_d);
        end else if (timeout_q == TO_LAST) begin
          state_d    = STALL;
          timeout_d  = '0;
          cand_d     = CODE_NONE;
          cand_cnt_d = '0;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
    endcase

    if (!enable) begin
      state_d    = IDLE;
      cand_d     = CODE_NONE;
      cand_cnt_d = '0;
      timeout_d  = '0;
    end
  end

  always_comb begin
    duty    = '0;
    dir_l_d = 1'b0;
    dir_r_d = 1'b0;
    case (state_q)
      FORWARD: begin duty = PW'(FWD_DUTY);  dir_l_d = 1'b1; dir_r_d = 1'b1; end
      TURN_L:  begin duty = PW'(TURN_DUTY); dir_l_d = 1'b0; dir_r_d = 1'b1; end
      TURN_R:  begin duty = PW'(TURN_DUTY); dir_l_d = 1'b1; dir_r_d = 1'b0; end
      SCAN:    begin duty = PW'(SCAN_DUTY); dir_l_d = 1'b1; dir_r_d = 1'b0; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= CODE_NONE;
      cand_cnt_q <= '0;
      timeout_q  <= '0;
      pwm_cnt_q  <= '0;
      pwm_left   <= 1'b0;
      pwm_right  <= 1'b0;
      dir_left   <= 1'b0;
      dir_right  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cand_cnt_q <= cand_cnt_d;
      timeout_q  <= timeout_d;
      pwm_cnt_q  <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
      pwm_left   <= (pwm_cnt_q < duty);
      pwm_right  <= (pwm_cnt_q < duty);
      dir_left   <= dir_l_d;
      dir_right  <= dir_r_d;
    end
  end

  assign state = state_q;

endmodule
